beta_fetch_unit: RTL and testbench

Instruction fetch stage (ifs) driven by the global pipeline control unit's fetch-enable / busy handshake. On each enable it performs one instruction-memory transaction at the current PC and holds the fetched word until the if-to-dec pipe (pip0) accepts it. It then advances the PC and signals idle. It sits between the imem port and the pip0 register and accepts PC redirects from the execution stage.

---
 rtl/beta_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_beta_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_fetch_unit.sv
// beta_fetch_unit - instruction fetch stage.
//
// Each fetch enable from the pipeline control unit produces exactly one
// imem transaction at the current PC. The fetched word is held for the
// if-to-dec pipe register until that register accepts it, and the PC then
// advances by 4. A redirect from the execution stage replaces the PC. If a
// transaction is in flight when the redirect arrives, the transaction is
// completed and its data is discarded.
//
// Ports
//   clk_i, rstn_i           clock, async active-low reset
//   pcu_ifs_fetch_en_i      start a fetch (sampled in IDLE only)
//   pcu_ifs_busy_o          fetch in flight or instruction not yet handed off
//   pcu_pip0_stall_i        pip0 cannot accept the held instruction
//   pcu_pip0_flush_i        drop the held instruction
//   ifs_redirect_valid_i    redirect request, target in ifs_redirect_pc_i
//   imem_req_o/addr_o       memory request and address
//   imem_gnt_i              request accepted
//   imem_rvalid_i/rdata_i   response valid and instruction word
//   ifs_instr_o/pc_o        held instruction and its PC
//   ifs_instr_valid_o       held instruction valid
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; waiting for fetch enable
// REQ   | request driven at the latched fetch address until granted
// WAIT  | granted; waiting for the response data
// HOLD  | instruction held for pip0 until hand-off, flush or redirect

module beta_fetch_unit #(
  parameter int                   DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 pcu_ifs_fetch_en_i,
  output logic                 pcu_ifs_busy_o,
  input  logic                 pcu_pip0_stall_i,
  input  logic                 pcu_pip0_flush_i,
  input  logic                 ifs_redirect_valid_i,
  input  logic [DataWidth-1:0] ifs_redirect_pc_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic [DataWidth-1:0] ifs_instr_o,
  output logic [DataWidth-1:0] ifs_pc_o,
  output logic                 ifs_instr_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0] fetch_addr_q, fetch_addr_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [DataWidth-1:0] instr_pc_q, instr_pc_d;
  logic                 kill_q, kill_d;

  logic [DataWidth-1:0] redirect_pc;
  logic [DataWidth-1:0] pc_inc;

  assign redirect_pc = {ifs_redirect_pc_i[DataWidth-1:2], 2'b00};
  assign pc_inc      = pc_q + DataWidth'(4);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= ResetPc;
      fetch_addr_q <= ResetPc;
      instr_q      <= '0;
      instr_pc_q   <= ResetPc;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    kill_d       = kill_q;

    unique case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (ifs_redirect_valid_i) pc_d = redirect_pc;
        if (pcu_ifs_fetch_en_i) begin
          state_d      = ST_REQ;
          // A redirect in the same cycle as the enable already steers this fetch.
          fetch_addr_d = ifs_redirect_valid_i ? redirect_pc : pc_q;
        end
      end

      ST_REQ: begin
        // The request address comes from fetch_addr_q. A redirect therefore
        // cannot alter a request that is still waiting for grant.
        if (ifs_redirect_valid_i) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
        if (imem_gnt_i) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (ifs_redirect_valid_i) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
        if (imem_rvalid_i) begin
          if (kill_q || ifs_redirect_valid_i) begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = fetch_addr_q;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (ifs_redirect_valid_i) begin
          pc_d    = redirect_pc;
          state_d = ST_IDLE;
        end else if (pcu_pip0_flush_i) begin
          state_d = ST_IDLE;
        end else if (!pcu_pip0_stall_i) begin
          pc_d    = pc_inc;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pcu_ifs_busy_o    = (state_q != ST_IDLE);
  assign imem_req_o        = (state_q == ST_REQ);
  assign imem_addr_o       = (state_q == ST_REQ) ? fetch_addr_q : pc_q;
  assign ifs_instr_o       = instr_q;
  assign ifs_pc_o          = instr_pc_q;
  assign ifs_instr_valid_o = (state_q == ST_HOLD) && !kill_q;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Testbench for beta_fetch_unit. A fixed vector table drives directed
// transactions first. Randomised transactions follow, and their
// expectations come from a transaction-level PC model. Hand-written
// sequences cover reset and reset in the middle of a transaction.

module tb_beta_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        busy;
  logic        stall;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ivalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beta_fetch_unit #(.DataWidth(32), .ResetPc(32'h0)) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .pcu_ifs_fetch_en_i   (fetch_en),
    .pcu_ifs_busy_o       (busy),
    .pcu_pip0_stall_i     (stall),
    .pcu_pip0_flush_i     (flush),
    .ifs_redirect_valid_i (redir_valid),
    .ifs_redirect_pc_i    (redir_pc),
    .imem_req_o           (req),
    .imem_addr_o          (addr),
    .imem_gnt_i           (gnt),
    .imem_rvalid_i        (rvalid),
    .imem_rdata_i         (rdata),
    .ifs_instr_o          (instr),
    .ifs_pc_o             (ipc),
    .ifs_instr_valid_o    (ivalid)
  );

  // kind: 0 normal, 1 redirect in REQ before grant, 2 redirect in WAIT,
  // 3 redirect in HOLD, 4 flush in HOLD, 5 redirect+flush in HOLD,
  // 6 redirect on the grant cycle, 7 redirect in IDLE (no fetch)
  typedef struct {
    int          kind;
    int          gdel;
    int          rdel;
    int          stall_cyc;
    logic [31:0] data;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    bit          exp_deliver;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    stall = 1'b0; flush = 1'b0; redir_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    redir_pc = v.tgt;
    if (v.kind == 7) begin
      redir_valid = 1'b1;
      step();
      redir_valid = 1'b0;
      chk("idle_redirect_busy", 32'(busy), 32'h0);
      chk("idle_redirect_addr", addr, v.exp_next);
      return;
    end
    chk("idle_addr", addr, v.exp_addr);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("req_high", 32'(req), 32'h1);
    chk("req_addr", addr, v.exp_addr);
    chk("req_busy", 32'(busy), 32'h1);
    if (v.kind == 1) begin
      redir_valid = 1'b1;
      step();
      redir_valid = 1'b0;
      chk("req_after_redirect", 32'(req), 32'h1);
      chk("req_addr_after_redirect", addr, v.exp_addr);
    end
    for (int i = 0; i < v.gdel; i++) begin
      step();
      chk("req_stable", 32'(req), 32'h1);
      chk("req_addr_stable", addr, v.exp_addr);
      chk("req_busy_stable", 32'(busy), 32'h1);
    end
    gnt = 1'b1;
    if (v.kind == 6) redir_valid = 1'b1;
    step();
    gnt = 1'b0;
    redir_valid = 1'b0;
    chk("wait_req_low", 32'(req), 32'h0);
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_valid_low", 32'(ivalid), 32'h0);
    if (v.kind == 2) begin
      redir_valid = 1'b1;
      step();
      redir_valid = 1'b0;
      chk("wait_redirect_valid_low", 32'(ivalid), 32'h0);
    end
    for (int i = 0; i < v.rdel; i++) begin
      step();
      chk("wait_valid_low", 32'(ivalid), 32'h0);
      chk("wait_busy", 32'(busy), 32'h1);
    end
    rvalid = 1'b1;
    rdata = v.data;
    step();
    rvalid = 1'b0;
    rdata = $urandom;
    if (!v.exp_deliver) begin
      chk("killed_valid_low", 32'(ivalid), 32'h0);
      chk("killed_busy_low", 32'(busy), 32'h0);
    end else begin
      chk("hold_valid", 32'(ivalid), 32'h1);
      chk("hold_instr", instr, v.data);
      chk("hold_pc", ipc, v.exp_addr);
      chk("hold_busy", 32'(busy), 32'h1);
      for (int i = 0; i < v.stall_cyc; i++) begin
        stall = 1'b1;
        step();
        chk("stall_valid", 32'(ivalid), 32'h1);
        chk("stall_instr", instr, v.data);
        chk("stall_pc", ipc, v.exp_addr);
        chk("stall_busy", 32'(busy), 32'h1);
      end
      stall = 1'b0;
      if (v.kind >= 3 && v.kind <= 5) stall = 1'($urandom_range(0, 1));
      if (v.kind == 3 || v.kind == 5) redir_valid = 1'b1;
      if (v.kind == 4 || v.kind == 5) flush = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0; redir_valid = 1'b0;
    end
    chk("end_busy_low", 32'(busy), 32'h0);
    chk("end_valid_low", 32'(ivalid), 32'h0);
    chk("next_addr", addr, v.exp_next);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] model_pc;
    vec_t        rv;

    vecs[0]  = '{0, 0, 0, 0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 32'h0000_0004};
    vecs[1]  = '{0, 3, 2, 0, 32'hA5A5_0001, 32'h0,         32'h0000_0004, 1'b1, 32'h0000_0008};
    vecs[2]  = '{0, 0, 0, 5, 32'h1234_5678, 32'h0,         32'h0000_0008, 1'b1, 32'h0000_000C};
    vecs[3]  = '{2, 0, 1, 0, 32'hDEAD_BEEF, 32'h0000_0103, 32'h0000_000C, 1'b0, 32'h0000_0100};
    vecs[4]  = '{3, 1, 1, 1, 32'h0BAD_F00D, 32'h0000_0020, 32'h0000_0100, 1'b1, 32'h0000_0020};
    vecs[5]  = '{5, 0, 0, 0, 32'h1111_2222, 32'h0000_0040, 32'h0000_0020, 1'b1, 32'h0000_0040};
    vecs[6]  = '{3, 0, 0, 0, 32'h3333_4444, 32'h0000_0022, 32'h0000_0040, 1'b1, 32'h0000_0020};
    vecs[7]  = '{4, 0, 0, 2, 32'h5555_6666, 32'h0,         32'h0000_0020, 1'b1, 32'h0000_0020};
    vecs[8]  = '{1, 2, 0, 0, 32'h7777_8888, 32'hFFFF_FFFE, 32'h0000_0020, 1'b0, 32'hFFFF_FFFC};
    vecs[9]  = '{0, 0, 0, 0, 32'h9999_AAAA, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0000};
    vecs[10] = '{6, 1, 0, 0, 32'hBBBB_CCCC, 32'h0000_0055, 32'h0000_0000, 1'b0, 32'h0000_0054};
    vecs[11] = '{7, 0, 0, 0, 32'h0,         32'h1000_0007, 32'h0,         1'b0, 32'h1000_0004};
    vecs[12] = '{0, 1, 1, 1, 32'hCAFE_0001, 32'h0,         32'h1000_0004, 1'b1, 32'h1000_0008};

    rstn = 1'b0; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
    redir_valid = 1'b0; redir_pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_valid", 32'(ivalid), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset while waiting for the response, then a stray response in IDLE.
    fetch_en = 1'b1; step(); fetch_en = 1'b0;
    gnt = 1'b1; step(); gnt = 1'b0;
    chk("midrst_pre_busy", 32'(busy), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_addr", addr, 32'h0);
    chk("midrst_req", 32'(req), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    rvalid = 1'b1; rdata = 32'hFACE_FACE;
    step();
    rvalid = 1'b0;
    chk("stray_rvalid_valid", 32'(ivalid), 32'h0);
    chk("stray_rvalid_busy", 32'(busy), 32'h0);

    // Random transactions checked against a PC-level model.
    model_pc = 32'h0;
    for (int n = 0; n < 150; n++) begin
      rv.kind      = int'($urandom_range(0, 7));
      rv.gdel      = int'($urandom_range(0, 3));
      rv.rdel      = int'($urandom_range(0, 2));
      rv.stall_cyc = int'($urandom_range(0, 3));
      rv.data      = $urandom;
      rv.tgt       = $urandom;
      if (n % 17 == 0) rv.tgt = 32'hFFFF_FFFC;
      rv.exp_addr    = model_pc;
      rv.exp_deliver = (rv.kind == 0) || (rv.kind >= 3 && rv.kind <= 5);
      case (rv.kind)
        0:       rv.exp_next = model_pc + 32'd4;
        4:       rv.exp_next = model_pc;
        default: rv.exp_next = rv.tgt & 32'hFFFF_FFFC;
      endcase
      do_txn(rv);
      model_pc = rv.exp_next;
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
